// File: rtl/fft_r2_seq.sv
// fft_r2_seq: address/control sequencer for an in-place radix-2 DIT FFT.
// Each cycle of a stage issues one butterfly read pair and a twiddle index.
// A PIPE_LAT-deep delay line turns every read into the matching write-back.
// Stages are separated by a drain gap, so a stage never reads a location
// before the previous stage has written it back.
// Optional feature: define FFT_SEQ_STALL_EN to add a stall input and a bf_ce
// clock-enable output for the butterfly and the RAM read register.
module fft_r2_seq #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FFT_SEQ_STALL_EN
  input  logic             stall,
  output logic             bf_ce,
`endif
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [LOG2N-1:0] stage
);

  localparam int KW = LOG2N - 1;
  localparam int CW = $clog2(PIPE_LAT + 1);

  localparam logic [KW-1:0]    K_LAST     = '1;
  localparam logic [LOG2N-1:0] ONE_A      = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N[LOG2N-1:0] - ONE_A;
  localparam logic [CW-1:0]    DRAIN_LOAD = CW'(PIPE_LAT);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [KW-1:0]     k, k_nx;
  logic [LOG2N-1:0]  stage_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              adv;
  logic              run_now;

  logic [KW-1:0]     mask, idx, grp, tw;
  logic [LOG2N-1:0]  span, addr_a, addr_b;

  logic [PIPE_LAT-1:0] dly_vld;
  logic [LOG2N-1:0]    dly_a [PIPE_LAT];
  logic [LOG2N-1:0]    dly_b [PIPE_LAT];

`ifdef FFT_SEQ_STALL_EN
  assign adv   = ~stall;
  assign bf_ce = ~stall;
`else
  assign adv   = 1'b1;
`endif

  assign run_now = (state == RUN);

  // State, butterfly counter, stage and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      stage <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      stage <= stage_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; everything holds while the sequencer is stalled
  always_comb begin
    state_nx = state;
    k_nx     = k;
    stage_nx = stage;
    cnt_nx   = cnt;
    if (adv) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            k_nx     = '0;
            stage_nx = '0;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            state_nx = DRAIN;
            cnt_nx   = DRAIN_LOAD;
          end else begin
            k_nx = k + KW'(1);
          end
        end
        DRAIN: begin
          if (cnt == CNT_ONE) begin
            if (stage == LAST_STAGE) begin
              state_nx = DONE;
            end else begin
              state_nx = RUN;
              stage_nx = stage + ONE_A;
              k_nx     = '0;
            end
          end else begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
        DONE: begin
          state_nx = IDLE;
          stage_nx = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Butterfly addressing: the low s bits of k select the position inside
  // a group, the remaining bits select the group of 2*span samples
  always_comb begin
    mask   = ~({KW{1'b1}} << stage);
    idx    = k & mask;
    grp    = k >> stage;
    span   = ONE_A << stage;
    addr_a = (({1'b0, grp} << stage) << 1) | {1'b0, idx};
    addr_b = addr_a + span;
    tw     = idx << (LAST_STAGE - stage);
  end

  // Read side outputs are only driven while a stage is issuing butterflies
  always_comb begin
    rd_en     = run_now & adv;
    rd_addr_a = run_now ? addr_a : '0;
    rd_addr_b = run_now ? addr_b : '0;
    tw_idx    = run_now ? tw : '0;
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE) & adv;
  end

  // Delay line carrying {valid, addr_a, addr_b} from read to write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dly_a[i] <= '0;
        dly_b[i] <= '0;
      end
    end else if (adv) begin
      dly_vld[0] <= rd_en;
      dly_a[0]   <= rd_addr_a;
      dly_b[0]   <= rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_vld[i] <= dly_vld[i-1];
        dly_a[i]   <= dly_a[i-1];
        dly_b[i]   <= dly_b[i-1];
      end
    end
  end

  // Write-back side comes straight off the end of the delay line
  always_comb begin
    wr_en     = dly_vld[PIPE_LAT-1] & adv;
    wr_addr_a = dly_a[PIPE_LAT-1];
    wr_addr_b = dly_b[PIPE_LAT-1];
  end

endmodule

// File: tb/tb_fft_r2_seq.sv
// tb_fft_r2_seq: scoreboard bench for fft_r2_seq (LOG2N=4, PIPE_LAT=3).
// Stimulus pushes the expected read/write/done events; a negedge monitor
// pops and compares whenever the sequencer presents rd_en, wr_en or done.
module tb_fft_r2_seq;

  localparam int LOG2N     = 4;
  localparam int PL        = 3;
  localparam int N         = 16;
  localparam int HALF      = N / 2;
  localparam int STAGE_CYC = HALF + PL;
  localparam int LAT       = LOG2N * STAGE_CYC + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
`ifdef FFT_SEQ_STALL_EN
  logic             stall = 1'b0;
  logic             bf_ce;
`endif
  logic             busy, done, rd_en, wr_en;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [LOG2N-2:0] tw_idx;

  fft_r2_seq #(.LOG2N(LOG2N), .PIPE_LAT(PL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef FFT_SEQ_STALL_EN
    .stall     (stall),
    .bf_ce     (bf_ce),
`endif
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  // Free-running clock and absolute cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int stg;
    int k;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  ev_t rlog[$];
  int  doneq[$];
  int  busy_lo = -10;
  int  busy_hi = -20;
  bit  log_en = 1'b0;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outvec();
    return int'({rd_en, wr_en, busy, done, stage, rd_addr_a, rd_addr_b,
                 tw_idx, wr_addr_a, wr_addr_b});
  endfunction

  function automatic int shifted(input int c, input int lim, input int len);
    return (c >= lim) ? c + len : c;
  endfunction

  // Expected events for one transform accepted in cycle base; a stall of
  // len cycles starting at base+at pushes every later event back by len
  task automatic applyStimulus(input int base, input int at, input int len);
    ev_t e;
    int  n, span, groups;
    for (int s = 0; s < LOG2N; s++) begin
      span   = 1 << s;
      groups = N / (2 * span);
      n      = 0;
      for (int g = 0; g < groups; g++) begin
        for (int j = 0; j < span; j++) begin
          e.a   = g * 2 * span + j;
          e.b   = e.a + span;
          e.tw  = j * groups;
          e.stg = s;
          e.k   = n;
          e.cyc = shifted(base + 1 + s * STAGE_CYC + n, base + at, len);
          rdq.push_back(e);
          e.cyc = shifted(base + 1 + s * STAGE_CYC + n + PL, base + at, len);
          wrq.push_back(e);
          n++;
        end
      end
    end
    doneq.push_back(shifted(base + LAT, base + at, len));
    busy_lo = base + 1;
    busy_hi = shifted(base + LAT - 1, base + at, len);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input int limit);
    int n = 0;
    while ((rdq.size() + wrq.size() + doneq.size()) > 0 && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("queues_drained", rdq.size() + wrq.size() + doneq.size(), 0);
    repeat (4) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: compare every presented event against the scoreboard queues
  always @(negedge clk) begin
    ev_t e;
    ev_t act;
    if (rst_n) begin
      if (rd_en) begin
        if (rdq.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          e = rdq.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr_a", int'(rd_addr_a), e.a);
          check("rd_addr_b", int'(rd_addr_b), e.b);
          check("tw_idx", int'(tw_idx), e.tw);
          check("stage", int'(stage), e.stg);
          if (e.k == 0 && e.stg > 0)
            check("raw_hazard", int'(wrq.size() > 0 && wrq[0].stg < e.stg), 0);
          if (log_en) begin
            act.cyc = cyc;
            act.a   = int'(rd_addr_a);
            act.b   = int'(rd_addr_b);
            act.tw  = int'(tw_idx);
            act.stg = int'(stage);
            act.k   = 0;
            rlog.push_back(act);
          end
        end
      end
      if (wr_en) begin
        if (wrq.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          e = wrq.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr_a", int'(wr_addr_a), e.a);
          check("wr_addr_b", int'(wr_addr_b), e.b);
        end
      end
      if (done) begin
        if (doneq.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, doneq.pop_front());
      end
      check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // Directed sequence of transforms, dropped starts, reset and stall
  initial begin
    int base;
    #3;
    check("reset_outputs", outvec(), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    repeat (20) begin
      @(posedge clk);
      #2;
      check("idle_outputs", outvec(), 0);
    end

    // Transform A with starts at cycle 10 and at the done cycle
    @(posedge clk);
    #2;
    base = cyc;
    applyStimulus(base, 0, 0);
    log_en = 1'b1;
    start  = 1'b1;
    goto(base + 1);
    start = 1'b0;
    goto(base + 10);
    start = 1'b1;
    goto(base + 11);
    start = 1'b0;
    goto(base + 45);
    log_en = 1'b0;
    start  = 1'b1;
    goto(base + 46);
    // Transform B: the start held into the cycle after done is accepted
    applyStimulus(cyc, 0, 0);
    goto(base + 47);
    start = 1'b0;

    check("rlog_count", rlog.size(), 2 * LOG2N * HALF / 2);
    if (rlog.size() >= 32) begin
      check("first_rd_a", rlog[0].a, 0);
      check("first_rd_b", rlog[0].b, 1);
      check("first_rd_tw", rlog[0].tw, 0);
      check("second_rd_a", rlog[1].a, 2);
      check("second_rd_b", rlog[1].b, 3);
      check("s1k1_a", rlog[9].a, 1);
      check("s1k1_b", rlog[9].b, 3);
      check("s1k1_tw", rlog[9].tw, 4);
      check("s2k5_a", rlog[21].a, 9);
      check("s2k5_b", rlog[21].b, 13);
      check("s2k5_tw", rlog[21].tw, 2);
      check("s3k7_a", rlog[31].a, 7);
      check("s3k7_b", rlog[31].b, 15);
      check("s3k7_tw", rlog[31].tw, 7);
    end
    checkOutput(200);

    // Transform C interrupted by reset at cycle 20
    base = cyc;
    applyStimulus(base, 0, 0);
    start = 1'b1;
    goto(base + 1);
    start = 1'b0;
    goto(base + 20);
    rst_n = 1'b0;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    busy_lo = -10;
    busy_hi = -20;
    #1;
    check("reset_async_outputs", outvec(), 0);
    goto(base + 22);
    rst_n = 1'b1;
    goto(base + 25);
    check("post_reset_idle", outvec(), 0);

    // Transform D: full run after reset
    base = cyc;
    applyStimulus(base, 0, 0);
    start = 1'b1;
    goto(base + 1);
    start = 1'b0;
    checkOutput(200);

`ifdef FFT_SEQ_STALL_EN
    // Transform E: five stall cycles in the middle of the first stage
    base = cyc;
    applyStimulus(base, 4, 5);
    start = 1'b1;
    goto(base + 1);
    start = 1'b0;
    goto(base + 4);
    stall = 1'b1;
    check("bf_ce_stalled", int'(bf_ce), 0);
    goto(base + 9);
    stall = 1'b0;
    check("bf_ce_running", int'(bf_ce), 1);
    checkOutput(200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
